// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner, BRAM read issue and 2-deep fetch buffer feeding the decoder
// Reads are issued only when the buffer is guaranteed room for every outstanding word.

module fetch_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] tail_data;
  logic         do_pop;

  assign do_pop = pop && (count != 2'd0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_data <= '0;
      tail_data <= '0;
      count     <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (count == 2'd0) head_data <= push_data;
          else               tail_data <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          count     <= count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (count == 2'd1) begin
            head_data <= push_data;
          end else begin
            head_data <= tail_data;
            tail_data <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   rstn,
  output logic                   imem_en,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  input  logic                   imem_busy,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [31:0]            inst,
  output logic [31:0]            inst_pc,
  output logic [6:0]             opcode,
  output logic [2:0]             funct3,
  output logic [6:0]             funct7
);

  logic [31:0] pc;
  logic [31:0] tag;
  logic        inflight;
  logic [1:0]  count;
  logic [63:0] head;
  logic        pop;
  logic        push;
  logic [2:0]  occupancy;
  logic [1:0]  unused_rpc_lsb;

  assign unused_rpc_lsb = redirect_pc[1:0];

  assign pop       = inst_valid & inst_ready;
  // A word returning in the redirect cycle belongs to the old path.
  assign push      = inflight & ~redirect;
  assign occupancy = {1'b0, count} + {2'b00, inflight};

  // Issue only if buffered + outstanding words, less the one leaving now, leave a free slot.
  assign imem_en   = rstn & ~redirect & ~imem_busy &
                     (occupancy < (3'd2 + {2'b00, pop}));
  assign imem_addr = pc[IMEM_ADDR_W+1:2];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc       <= {RESET_PC[31:2], 2'b00};
      tag      <= 32'h0;
      inflight <= 1'b0;
    end else if (redirect) begin
      pc       <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= imem_en;
      if (imem_en) begin
        tag <= pc;
        pc  <= pc + 32'd4;
      end
    end
  end

  fetch_fifo #(.W(64)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (redirect),
    .push      (push),
    .push_data ({tag, imem_rdata}),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

  assign inst_valid = (count != 2'd0);
  assign inst       = head[31:0];
  assign inst_pc    = head[63:32];
  assign opcode     = inst[6:0];
  assign funct3     = inst[14:12];
  assign funct7     = inst[31:25];

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized self-checking bench for instruction_fetch
// The reference tracks the expected instruction address stream and restarts it on redirect/reset.

module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_en;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_busy;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  logic [31:0] mem [0:16383];

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_issue;
  logic        hold_pending = 1'b0;
  logic [31:0] held_inst;
  logic [31:0] held_pc;
  logic        prev_rst = 1'b0;
  logic        busy1 = 1'b0;
  int          since_ev = 100;

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  instruction_fetch #(.RESET_PC(RESET_PC), .IMEM_ADDR_W(14)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_busy   (imem_busy),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // One clock cycle: drive at negedge, check the settled outputs, advance the reference.
  task automatic tick(input logic rdy, input logic bsy, input logic rd,
                      input logic [31:0] rpc, input logic rs);
    logic [31:0] word;
    @(negedge clk);
    inst_ready = rdy; imem_busy = bsy; redirect = rd; redirect_pc = rpc; rstn = rs;
    #1;
    since_ev++;
    if (prev_rst) begin
      check_eq("rst_valid", {31'h0, inst_valid}, 32'h0);
      check_eq("rst_inst", inst, 32'h0);
      check_eq("rst_pc", inst_pc, 32'h0);
    end
    if (!rs || rd || bsy) check_eq("en_blocked", {31'h0, imem_en}, 32'h0);
    if (imem_en) begin
      check_eq("issue_addr", {18'h0, imem_addr}, {18'h0, exp_issue[15:2]});
      exp_issue = exp_issue + 32'd4;
    end
    if (hold_pending) begin
      check_eq("hold_valid", {31'h0, inst_valid}, 32'h1);
      check_eq("hold_inst", inst, held_inst);
      check_eq("hold_pc", inst_pc, held_pc);
    end
    if (since_ev == 1) busy1 = bsy;
    if (since_ev == 1 || since_ev == 2) check_eq("gap_valid", {31'h0, inst_valid}, 32'h0);
    if (since_ev == 3 && !busy1) check_eq("first_valid", {31'h0, inst_valid}, 32'h1);
    if (inst_valid && rdy && rs && !rd) begin
      word = mem[exp_pc[15:2]];
      check_eq("inst_pc", inst_pc, exp_pc);
      check_eq("inst", inst, word);
      check_eq("fields", {15'h0, funct7, funct3, opcode},
               {15'h0, word[31:25], word[14:12], word[6:0]});
      exp_pc = exp_pc + 32'd4;
    end
    hold_pending = rs && !rd && inst_valid && !rdy;
    held_inst = inst;
    held_pc = inst_pc;
    prev_rst = !rs;
    if (!rs) begin
      exp_pc = RESET_PC; exp_issue = RESET_PC; since_ev = 0;
    end else if (rd) begin
      exp_pc = {rpc[31:2], 2'b00}; exp_issue = exp_pc; since_ev = 0;
    end
  endtask

  initial begin
    logic        r_rdy, r_bsy, r_rd, r_rs;
    logic [31:0] r_pc;
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    rstn = 1'b0; inst_ready = 1'b0; imem_busy = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    exp_pc = RESET_PC; exp_issue = RESET_PC;

    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      if (i == 0) check_eq("start_en", {31'h0, imem_en}, 32'h1);
      if (i >= 2) check_eq("stream_valid", {31'h0, inst_valid}, 32'h1);
    end

    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      if (i >= 1) check_eq("stall_en", {31'h0, imem_en}, 32'h0);
    end
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("redir_pc", inst_pc, 32'h100);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      check_eq("busy_en", {31'h0, imem_en}, 32'h0);
    end
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    tick(1'b1, 1'b0, 1'b1, 32'h103, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("redir_addr", {18'h0, imem_addr}, 32'h40);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    tick(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("pre_rst_valid", {31'h0, inst_valid}, 32'h1);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      r_rs  = ($urandom_range(0, 99) >= 2);
      r_rdy = ($urandom_range(0, 99) < 70);
      r_bsy = ($urandom_range(0, 99) < 15);
      r_rd  = r_rs && ($urandom_range(0, 99) < 5);
      case ($urandom_range(0, 2))
        0:       r_pc = $urandom;
        1:       r_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        default: r_pc = $urandom & 32'h3FF;
      endcase
      tick(r_rdy, r_bsy, r_rd, r_pc, r_rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
